// File: rtl/lzw_pkg.sv
// lzw_pkg: shared definitions for the LZW encoder front end.
//   - Dictionary geometry (address/code width, word width, depth, first
//     free code).
//   - code_t / dict_word_t typedefs and the controller state enum.
//   - The dictionary hash and the linear-probe address step.
package lzw_pkg;

  localparam int ADDR_WIDTH      = 11;
  localparam int DATA_WIDTH      = 64;
  localparam int FIRST_FREE_CODE = 256;
  localparam int DICT_DEPTH      = 2048;
  // Hashes below FIRST_FREE_CODE are folded into the top of the table so
  // that probing never touches the region reserved for single-byte codes.
  localparam int HASH_FOLD_BASE  = DICT_DEPTH - FIRST_FREE_CODE;

  typedef logic [ADDR_WIDTH-1:0] code_t;
  typedef logic [DATA_WIDTH-1:0] dict_word_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_CHK,
    ST_EMIT,
    ST_INS,
    ST_RESTART,
    ST_LASTCHK,
    ST_FLUSH
  } state_t;

  // XOR-fold of the 64-bit string word into 11 bits; the top chunk is only
  // 9 bits wide and is zero-extended.
  function automatic code_t lzw_hash_addr(input dict_word_t t);
    code_t h;
    h = t[10:0] ^ t[21:11] ^ t[32:22] ^ t[43:33] ^ t[54:44] ^ {2'b00, t[63:55]};
    if (h < code_t'(FIRST_FREE_CODE)) begin
      return h + code_t'(HASH_FOLD_BASE);
    end
    return h;
  endfunction

  // Next probe address; wraps from the last entry back to the first
  // dynamically assigned entry.
  function automatic code_t lzw_probe_step(input code_t a);
    if (a == code_t'(DICT_DEPTH - 1)) begin
      return code_t'(FIRST_FREE_CODE);
    end
    return a + code_t'(1);
  endfunction

endpackage

// File: rtl/lzw_hash.sv
// lzw_hash: combinational start address for a dictionary probe.
//   word : candidate string word {len, bytes}
//   addr : first dictionary address to probe (always >= 256)
module lzw_hash
  import lzw_pkg::*;
(
  input  dict_word_t word,
  output code_t      addr
);

  assign addr = lzw_hash_addr(word);

endmodule

// File: rtl/lzw_encoder_ctrl.sv
// lzw_encoder_ctrl: LZW compression controller in front of the dictionary RAM.
//   byte_in/byte_valid/byte_last/byte_ready : input byte stream (valid/ready)
//   code_out/code_valid/code_last/code_ready : 11-bit output code stream
//   dict_addr/dict_data/dict_cs/dict_we     : dictionary command (read: addr
//                                             held two cycles, data sampled in
//                                             the second; write: one cycle)
//   dict_valid/dict_rdata/dict_map          : dictionary read response
//   dict_count                              : next code the RAM will assign;
//                                             zero means the table is full
module lzw_encoder_ctrl
  import lzw_pkg::*;
#(
  parameter int MAX_LEN   = 7,
  parameter int MAX_PROBE = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  input  logic                  byte_last,
  output logic                  byte_ready,
  output logic [ADDR_WIDTH-1:0] code_out,
  output logic                  code_valid,
  output logic                  code_last,
  input  logic                  code_ready,
  output logic [ADDR_WIDTH-1:0] dict_addr,
  output logic [DATA_WIDTH-1:0] dict_data,
  output logic                  dict_cs,
  output logic                  dict_we,
  input  logic                  dict_valid,
  input  logic [DATA_WIDTH-1:0] dict_rdata,
  input  logic [ADDR_WIDTH-1:0] dict_map,
  input  logic [ADDR_WIDTH-1:0] dict_count
);

  state_t     state_reg, state_next;
  dict_word_t s_reg, s_next;        // current matched string
  dict_word_t t_reg, t_next;        // candidate (string + new byte)
  code_t      c_reg, c_next;        // code of the current string
  code_t      addr_reg, addr_next;  // probe / insert address
  logic [3:0] probe_reg, probe_next;
  logic [7:0] b_reg, b_next;        // byte being consumed
  logic       last_reg, last_next;  // that byte closed the stream
  logic       free_reg, free_next;  // addr_reg is an empty slot for insert
  // Keeps byte_ready low while reset is applied so every output reads 0,
  // even though IDLE is the reset state.
  logic       armed_reg;

  logic [7:0] len;
  dict_word_t cand;
  code_t      hash_addr;
  logic       dict_full;

  assign len       = s_reg[63:56];
  assign cand      = {len + 8'd1, s_reg[47:0], byte_in};
  assign dict_full = (dict_count == '0);

  lzw_hash u_hash (
    .word (cand),
    .addr (hash_addr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      s_reg     <= '0;
      t_reg     <= '0;
      c_reg     <= '0;
      addr_reg  <= '0;
      probe_reg <= '0;
      b_reg     <= '0;
      last_reg  <= 1'b0;
      free_reg  <= 1'b0;
      armed_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      s_reg     <= s_next;
      t_reg     <= t_next;
      c_reg     <= c_next;
      addr_reg  <= addr_next;
      probe_reg <= probe_next;
      b_reg     <= b_next;
      last_reg  <= last_next;
      free_reg  <= free_next;
      armed_reg <= 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    s_next     = s_reg;
    t_next     = t_reg;
    c_next     = c_reg;
    addr_next  = addr_reg;
    probe_next = probe_reg;
    b_next     = b_reg;
    last_next  = last_reg;
    free_next  = free_reg;

    byte_ready = 1'b0;
    code_out   = '0;
    code_valid = 1'b0;
    code_last  = 1'b0;
    dict_addr  = '0;
    dict_data  = '0;
    dict_cs    = 1'b0;
    dict_we    = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        byte_ready = armed_reg;
        if (armed_reg && byte_valid) begin
          b_next    = byte_in;
          last_next = byte_last;
          if (len == 8'd0) begin
            // Single-byte strings are implicit: code is the byte itself.
            s_next     = {8'd1, 48'd0, byte_in};
            c_next     = {3'b000, byte_in};
            state_next = ST_LASTCHK;
          end else if (len >= 8'(MAX_LEN)) begin
            // Cannot grow further: emit without probing or inserting.
            free_next  = 1'b0;
            state_next = ST_EMIT;
          end else begin
            t_next     = cand;
            addr_next  = hash_addr;
            probe_next = '0;
            state_next = ST_RD;
          end
        end
      end

      ST_RD: begin
        dict_addr  = addr_reg;
        dict_cs    = 1'b1;
        state_next = ST_CHK;
      end

      ST_CHK: begin
        dict_addr = addr_reg;
        dict_cs   = 1'b1;
        if (dict_valid) begin
          if (dict_rdata == t_reg) begin
            s_next     = t_reg;
            c_next     = dict_map;
            state_next = ST_LASTCHK;
          end else if (probe_reg < 4'(MAX_PROBE - 1)) begin
            probe_next = probe_reg + 4'd1;
            addr_next  = lzw_probe_step(addr_reg);
            state_next = ST_RD;
          end else begin
            free_next  = 1'b0;
            state_next = ST_EMIT;
          end
        end else begin
          free_next  = 1'b1;
          state_next = ST_EMIT;
        end
      end

      ST_EMIT: begin
        code_out   = c_reg;
        code_valid = 1'b1;
        if (code_ready) begin
          state_next = (free_reg && !dict_full) ? ST_INS : ST_RESTART;
        end
      end

      ST_INS: begin
        dict_addr  = addr_reg;
        dict_data  = t_reg;
        dict_cs    = 1'b1;
        dict_we    = 1'b1;
        state_next = ST_RESTART;
      end

      ST_RESTART: begin
        s_next     = {8'd1, 48'd0, b_reg};
        c_next     = {3'b000, b_reg};
        state_next = ST_LASTCHK;
      end

      ST_LASTCHK: begin
        state_next = last_reg ? ST_FLUSH : ST_IDLE;
      end

      ST_FLUSH: begin
        code_out   = c_reg;
        code_valid = 1'b1;
        code_last  = 1'b1;
        if (code_ready) begin
          s_next     = '0;
          state_next = ST_IDLE;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_lzw_encoder_ctrl.sv
module tb_lzw_encoder_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_last;
  logic        byte_ready;
  logic [10:0] code_out;
  logic        code_valid;
  logic        code_last;
  logic        code_ready;
  logic [10:0] dict_addr;
  logic [63:0] dict_data;
  logic        dict_cs;
  logic        dict_we;
  logic        dict_valid;
  logic [63:0] dict_rdata;
  logic [10:0] dict_map;
  logic [10:0] dict_count;

  always #5 clk = ~clk;

  lzw_encoder_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_last  (byte_last),
    .byte_ready (byte_ready),
    .code_out   (code_out),
    .code_valid (code_valid),
    .code_last  (code_last),
    .code_ready (code_ready),
    .dict_addr  (dict_addr),
    .dict_data  (dict_data),
    .dict_cs    (dict_cs),
    .dict_we    (dict_we),
    .dict_valid (dict_valid),
    .dict_rdata (dict_rdata),
    .dict_map   (dict_map),
    .dict_count (dict_count)
  );

  int checks = 0;
  int errors = 0;

  // Dictionary RAM model with registered read, plus activity logs.
  logic        mem_valid [2048];
  logic [63:0] mem_word  [2048];
  logic [10:0] mem_map   [2048];
  logic [10:0] count;
  logic        mdl_clear = 1'b0;
  logic        pre_we = 1'b0;
  logic [10:0] pre_addr = '0;
  logic [63:0] pre_word = '0;
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  int          code_cnt = 0;
  logic [10:0] last_wr_addr = '0;
  logic [63:0] last_wr_data = '0;
  logic [10:0] rd_log   [256];
  logic [11:0] code_log [256];
  logic        prev_rd = 1'b0;
  logic [10:0] prev_addr = '0;

  assign dict_count = count;

  always @(posedge clk) begin
    if (mdl_clear) begin
      for (int i = 0; i < 2048; i++) mem_valid[i] <= 1'b0;
      count <= 11'd256;
    end else if (pre_we) begin
      mem_valid[pre_addr] <= 1'b1;
      mem_word[pre_addr]  <= pre_word;
      mem_map[pre_addr]   <= count;
      count <= count + 11'd1;
    end else if (dict_cs && dict_we) begin
      mem_valid[dict_addr] <= 1'b1;
      mem_word[dict_addr]  <= dict_data;
      mem_map[dict_addr]   <= count;
      count        <= count + 11'd1;
      wr_cnt       <= wr_cnt + 1;
      last_wr_addr <= dict_addr;
      last_wr_data <= dict_data;
      $display("write addr %0d data %h code %0d", dict_addr, dict_data, count);
    end
    if (dict_cs && !dict_we) begin
      dict_valid <= mem_valid[dict_addr];
      dict_rdata <= mem_word[dict_addr];
      dict_map   <= mem_map[dict_addr];
      if (!prev_rd || dict_addr != prev_addr) begin
        rd_log[rd_cnt[7:0]] <= dict_addr;
        rd_cnt <= rd_cnt + 1;
      end
    end
    prev_rd   <= dict_cs && !dict_we;
    prev_addr <= dict_addr;
    if (code_valid && code_ready) begin
      code_log[code_cnt[7:0]] <= {code_last, code_out};
      code_cnt <= code_cnt + 1;
      $display("code %03h last %0b", code_out, code_last);
    end
  end

  function automatic logic [10:0] hash_ref(input logic [63:0] t);
    logic [10:0] h;
    h = t[10:0] ^ t[21:11] ^ t[32:22] ^ t[43:33] ^ t[54:44] ^ {2'b00, t[63:55]};
    return (h < 11'd256) ? h + 11'd1792 : h;
  endfunction

  function automatic logic [63:0] a_word(input int n);
    logic [63:0] w;
    w = '0;
    w[63:56] = 8'(n);
    for (int i = 0; i < n; i++) w[8*i +: 8] = 8'h61;
    return w;
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic last);
    int n;
    n = 0;
    @(negedge clk);
    byte_in = b; byte_valid = 1'b1; byte_last = last;
    while (!byte_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (byte_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_byte_timeout: byte_ready=%b required 1", byte_ready);
    end
    @(posedge clk); #1;
    $display("byte %02h last %0b", b, last);
    byte_valid = 1'b0; byte_last = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (!byte_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (byte_ready !== 1'b1) begin
      errors++;
      $display("FAIL wait_idle_timeout: byte_ready=%b required 1", byte_ready);
    end
  endtask

  task automatic clear_dict();
    @(negedge clk); mdl_clear = 1'b1;
    @(negedge clk); mdl_clear = 1'b0;
  endtask

  task automatic preload(input logic [63:0] w, input logic [10:0] start);
    logic [10:0] a;
    int n;
    a = start; n = 0;
    while (mem_valid[a] && n < 2048) begin
      a = (a == 11'd2047) ? 11'd256 : a + 11'd1;
      n++;
    end
    @(negedge clk); pre_we = 1'b1; pre_addr = a; pre_word = w;
    @(negedge clk); pre_we = 1'b0;
  endtask

  task automatic test_reset();
    logic [90:0] outs;
    rst = 1'b1; byte_in = '0; byte_valid = 1'b0; byte_last = 1'b0; code_ready = 1'b1;
    mdl_clear = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    outs = {byte_ready, code_valid, code_last, code_out, dict_cs, dict_we, dict_addr, dict_data};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0", outs);
    end
    @(negedge clk); mdl_clear = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (byte_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_after_release: got %b required 1", byte_ready);
    end
  endtask

  // "A" then "B" as two back-to-back one-byte streams.
  task automatic test_back_to_back();
    int c0, w0;
    logic [11:0] exp_c [2];
    logic [7:0] idx;
    c0 = code_cnt; w0 = wr_cnt;
    exp_c[0] = 12'h841; exp_c[1] = 12'h842;
    send_byte(8'h41, 1'b1);
    send_byte(8'h42, 1'b1);
    wait_idle();
    checks++;
    if (code_cnt - c0 !== 2) begin
      errors++;
      $display("FAIL b2b_code_count: got %0d required 2", code_cnt - c0);
    end
    for (int i = 0; i < 2; i++) begin
      idx = 8'(c0 + i);
      checks++;
      if (code_log[idx] !== exp_c[i]) begin
        errors++;
        $display("FAIL b2b_code%0d: got %h required %h", i, code_log[idx], exp_c[i]);
      end
    end
    checks++;
    if (wr_cnt !== w0) begin
      errors++;
      $display("FAIL b2b_no_write: got %0d writes required 0", wr_cnt - w0);
    end
  endtask

  task automatic test_miss_insert();
    int c0, w0, r0;
    logic [11:0] exp_c [2];
    logic [7:0] idx;
    c0 = code_cnt; w0 = wr_cnt; r0 = rd_cnt;
    exp_c[0] = 12'h041; exp_c[1] = 12'h842;
    send_byte(8'h41, 1'b0);
    send_byte(8'h42, 1'b1);
    wait_idle();
    for (int i = 0; i < 2; i++) begin
      idx = 8'(c0 + i);
      checks++;
      if (code_log[idx] !== exp_c[i]) begin
        errors++;
        $display("FAIL ab_code%0d: got %h required %h", i, code_log[idx], exp_c[i]);
      end
    end
    idx = 8'(r0);
    checks++;
    if (rd_cnt - r0 !== 1 || rd_log[idx] !== 11'd334) begin
      errors++;
      $display("FAIL ab_probe: got %0d reads first %0d required 1 read at 334", rd_cnt - r0, rd_log[idx]);
    end
    checks++;
    if (wr_cnt - w0 !== 1 || last_wr_addr !== 11'd334) begin
      errors++;
      $display("FAIL ab_write_addr: got %0d writes at %0d required 1 at 334", wr_cnt - w0, last_wr_addr);
    end
    checks++;
    if (last_wr_data !== 64'h0200000000004142) begin
      errors++;
      $display("FAIL ab_write_data: got %h required 0200000000004142", last_wr_data);
    end
    checks++;
    if (count !== 11'd257) begin
      errors++;
      $display("FAIL ab_dict_count: got %0d required 257", count);
    end
  endtask

  task automatic test_hit();
    int c0, w0, r0;
    logic [11:0] exp_c [2];
    logic [7:0] idx;
    c0 = code_cnt; w0 = wr_cnt; r0 = rd_cnt;
    exp_c[0] = 12'h100; exp_c[1] = 12'h900;
    send_byte(8'h41, 1'b0);
    send_byte(8'h42, 1'b0);
    send_byte(8'h41, 1'b0);
    send_byte(8'h42, 1'b1);
    wait_idle();
    checks++;
    if (code_cnt - c0 !== 2) begin
      errors++;
      $display("FAIL abab_code_count: got %0d required 2", code_cnt - c0);
    end
    for (int i = 0; i < 2; i++) begin
      idx = 8'(c0 + i);
      checks++;
      if (code_log[idx] !== exp_c[i]) begin
        errors++;
        $display("FAIL abab_code%0d: got %h required %h", i, code_log[idx], exp_c[i]);
      end
    end
    idx = 8'(r0);
    checks++;
    if (rd_log[idx] !== 11'd334) begin
      errors++;
      $display("FAIL abab_first_probe: got %0d required 334", rd_log[idx]);
    end
    checks++;
    if (wr_cnt - w0 !== 1 || last_wr_data !== 64'h0300000000414241 || count !== 11'd258) begin
      errors++;
      $display("FAIL abab_insert: got %0d writes data %h count %0d required 1 0300000000414241 258",
               wr_cnt - w0, last_wr_data, count);
    end
  endtask

  task automatic test_collision();
    int c0, w0, r0;
    logic [11:0] exp_c [2];
    logic [7:0] idx0, idx1;
    clear_dict();
    preload(64'h0500000000000001, 11'd334);
    c0 = code_cnt; w0 = wr_cnt; r0 = rd_cnt;
    exp_c[0] = 12'h041; exp_c[1] = 12'h842;
    send_byte(8'h41, 1'b0);
    send_byte(8'h42, 1'b1);
    wait_idle();
    for (int i = 0; i < 2; i++) begin
      idx0 = 8'(c0 + i);
      checks++;
      if (code_log[idx0] !== exp_c[i]) begin
        errors++;
        $display("FAIL coll_code%0d: got %h required %h", i, code_log[idx0], exp_c[i]);
      end
    end
    idx0 = 8'(r0); idx1 = 8'(r0 + 1);
    checks++;
    if (rd_cnt - r0 !== 2 || rd_log[idx0] !== 11'd334 || rd_log[idx1] !== 11'd335) begin
      errors++;
      $display("FAIL coll_probes: got %0d reads %0d,%0d required 2 reads 334,335",
               rd_cnt - r0, rd_log[idx0], rd_log[idx1]);
    end
    checks++;
    if (wr_cnt - w0 !== 1 || last_wr_addr !== 11'd335) begin
      errors++;
      $display("FAIL coll_write: got %0d writes at %0d required 1 at 335", wr_cnt - w0, last_wr_addr);
    end
  endtask

  task automatic test_max_len();
    int c0, w0, r0;
    logic [11:0] exp_a [4];
    logic [11:0] exp_b [2];
    logic [7:0] idx;
    clear_dict();
    c0 = code_cnt; w0 = wr_cnt;
    exp_a[0] = 12'h061; exp_a[1] = 12'h100; exp_a[2] = 12'h101; exp_a[3] = 12'h900;
    for (int i = 0; i < 8; i++) send_byte(8'h61, (i == 7));
    wait_idle();
    checks++;
    if (code_cnt - c0 !== 4) begin
      errors++;
      $display("FAIL rep_code_count: got %0d required 4", code_cnt - c0);
    end
    for (int i = 0; i < 4; i++) begin
      idx = 8'(c0 + i);
      checks++;
      if (code_log[idx] !== exp_a[i]) begin
        errors++;
        $display("FAIL rep_code%0d: got %h required %h", i, code_log[idx], exp_a[i]);
      end
    end
    checks++;
    if (wr_cnt - w0 !== 3 || count !== 11'd259) begin
      errors++;
      $display("FAIL rep_inserts: got %0d writes count %0d required 3 259", wr_cnt - w0, count);
    end
    // Extend the table with a^5..a^7 (codes 259..261) so the next stream
    // reaches the length cap.
    for (int n = 5; n <= 7; n++) preload(a_word(n), hash_ref(a_word(n)));
    c0 = code_cnt; w0 = wr_cnt;
    exp_b[0] = 12'h105; exp_b[1] = 12'h861;
    for (int i = 0; i < 7; i++) send_byte(8'h61, 1'b0);
    wait_idle();
    r0 = rd_cnt;
    send_byte(8'h61, 1'b1);
    wait_idle();
    for (int i = 0; i < 2; i++) begin
      idx = 8'(c0 + i);
      checks++;
      if (code_log[idx] !== exp_b[i]) begin
        errors++;
        $display("FAIL cap_code%0d: got %h required %h", i, code_log[idx], exp_b[i]);
      end
    end
    checks++;
    if (rd_cnt !== r0) begin
      errors++;
      $display("FAIL cap_no_probe: got %0d reads required 0", rd_cnt - r0);
    end
    checks++;
    if (wr_cnt !== w0) begin
      errors++;
      $display("FAIL cap_no_insert: got %0d writes required 0", wr_cnt - w0);
    end
  endtask

  task automatic test_backpressure_reset();
    int c0, n;
    logic [90:0] outs;
    code_ready = 1'b0;
    send_byte(8'h51, 1'b0);
    send_byte(8'h52, 1'b0);
    c0 = code_cnt;
    n = 0;
    @(negedge clk);
    while (!code_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (code_valid !== 1'b1 || code_out !== 11'h051 || code_last !== 1'b0 || byte_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle%0d: got valid %b code %h last %b ready %b required 1 051 0 0",
                 i, code_valid, code_out, code_last, byte_ready);
      end
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    outs = {byte_ready, code_valid, code_last, code_out, dict_cs, dict_we, dict_addr, dict_data};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got %h required 0", outs);
    end
    @(posedge clk); #1;
    outs = {byte_ready, code_valid, code_last, code_out, dict_cs, dict_we, dict_addr, dict_data};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL midreset_held: got %h required 0", outs);
    end
    @(negedge clk); rst = 1'b0; code_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (byte_ready !== 1'b1 || code_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_idle: got ready %b valid %b required 1 0", byte_ready, code_valid);
    end
    checks++;
    if (code_cnt !== c0) begin
      errors++;
      $display("FAIL midreset_aborted: got %0d codes required 0", code_cnt - c0);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_miss_insert();
    test_hit();
    test_collision();
    test_max_len();
    test_backpressure_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
